// File: rtl/npc_pkg.sv
// Shared NPC definitions: fetch FSM states, fault causes, bus response codes, reset PC and NOP.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npc_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] FAULT_MISALIGN = 2'd0;
    localparam logic [1:0] FAULT_BUS      = 2'd1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IFU_IDLE,
        IFU_AR,
        IFU_R,
        IFU_HOLD,
        IFU_DRAIN,
        IFU_FAULT
    } ifu_state_e;

    // Instruction fetches must be 32-bit aligned (no compressed ISA on RV32E here).
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory read port (AR/R channels, valid/ready) between the IFU and memory.
// Latency: n/a (wires only).
// Backpressure: arready stalls the address phase, rready gates the data beat.
// Ports (master = IFU): araddr/arvalid out, arready in; rdata/rresp/rvalid in, rready out.
interface ifu_fetch_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr,
        output arvalid,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid,
        output rready
    );

    modport slave (
        input  araddr,
        input  arvalid,
        output arready,
        output rdata,
        output rresp,
        output rvalid,
        input  rready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: turns a core PC request into one memory read and holds the word until retired.
// Latency: 3 cycles request-to-inst_valid_o with a zero-wait memory; +1 cycle between back-to-back fetches.
// Backpressure: address phase waits on arready, result is held in HOLD until inst_ready_i or flush_i.
// Ports: clk/rst (sync, active-high); core side pc_i/pc_valid_i/flush_i in, inst_o/inst_valid_o/
//        inst_pc_o/fault_o/fault_cause_o out, inst_ready_i in; imem = memory read port (master).
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    input  logic              flush_i,

    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    output logic              fault_o,
    output logic [1:0]        fault_cause_o,

    ifu_fetch_if.master       imem
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [1:0]        cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IFU_IDLE;
            req_pc_q  <= RESET_PC[ADDR_W-1:0];
            drop_q    <= 1'b0;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC[ADDR_W-1:0];
            cause_q   <= FAULT_MISALIGN;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cause_d   = cause_q;

        unique case (state_q)
            IFU_IDLE: begin
                // A redirect in the same cycle wins over a new request.
                if (!flush_i && pc_valid_i) begin
                    if (is_word_aligned(pc_i[1:0])) begin
                        req_pc_d = pc_i;
                        state_d  = IFU_AR;
                    end else begin
                        cause_d = FAULT_MISALIGN;
                        state_d = IFU_FAULT;
                    end
                end
            end

            IFU_AR: begin
                // The address phase cannot be withdrawn once offered; a flush only
                // marks the eventual response as unwanted.
                if (imem.arready) begin
                    state_d = flush_i ? IFU_DRAIN : IFU_R;
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end

            IFU_R: begin
                if (imem.rvalid) begin
                    if (flush_i || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IFU_IDLE;
                    end else if (imem.rresp == RESP_OKAY) begin
                        inst_d    = imem.rdata;
                        inst_pc_d = req_pc_q;
                        state_d   = IFU_HOLD;
                    end else begin
                        cause_d = FAULT_BUS;
                        state_d = IFU_FAULT;
                    end
                end else if (flush_i) begin
                    state_d = IFU_DRAIN;
                end
            end

            IFU_DRAIN: begin
                // Swallow the abandoned beat so only one read is ever outstanding.
                if (imem.rvalid) begin
                    drop_d  = 1'b0;
                    state_d = IFU_IDLE;
                end
            end

            IFU_HOLD: begin
                if (inst_ready_i || flush_i) begin
                    state_d = IFU_IDLE;
                end
            end

            IFU_FAULT: begin
                if (flush_i) begin
                    cause_d = FAULT_MISALIGN;
                    state_d = IFU_IDLE;
                end
            end

            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    assign imem.araddr   = req_pc_q;
    assign imem.arvalid  = (state_q == IFU_AR);
    assign imem.rready   = (state_q == IFU_R) || (state_q == IFU_DRAIN);

    assign inst_o        = inst_q;
    assign inst_pc_o     = inst_pc_q;
    assign inst_valid_o  = (state_q == IFU_HOLD);
    assign fault_o       = (state_q == IFU_FAULT);
    assign fault_cause_o = cause_q;

endmodule
